// File: rtl/ex_pkg.sv
// Shared types for the RV32I ID/EX operand stage: ALU opcodes, operand selects,
// the registered ID/EX packet and the forwarding match rule.
// No logic latency; no flow control.
package ex_pkg;

    localparam int EX_XLEN   = 32;
    localparam int EX_REG_AW = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2  = 2'd0,
        OPB_IMM  = 2'd1,
        OPB_FOUR = 2'd2
    } opb_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [EX_XLEN-1:0]   pc;
        logic [EX_REG_AW-1:0] rs1_addr;
        logic [EX_REG_AW-1:0] rs2_addr;
        logic [EX_XLEN-1:0]   rs1_data;
        logic [EX_XLEN-1:0]   rs2_data;
        logic [EX_XLEN-1:0]   imm;
        logic [3:0]           alu_op;
        opa_sel_e             opa_sel;
        opb_sel_e             opb_sel;
        logic [EX_REG_AW-1:0] rd_addr;
        logic                 rd_wren;
        logic                 mem_rden;
    } id_ex_pkt_t;

    // Reset and flush both load this, so a bubble never carries stale fields.
    function automatic id_ex_pkt_t bubble_pkt();
        id_ex_pkt_t p;
        p          = '0;
        p.alu_op   = ALU_ADD;
        p.opa_sel  = OPA_RS1;
        p.opb_sel  = OPB_RS2;
        return p;
    endfunction

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    function automatic logic fwd_match(input logic [EX_REG_AW-1:0] rs,
                                       input logic [EX_REG_AW-1:0] rd,
                                       input logic                 wren);
        return wren && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Bypass select for one source register: MEM result, else WB result, else register file data.
// Purely combinational; no flow control.
// No backpressure.
module fwd_mux
    import ex_pkg::*;
#(
    parameter int XLEN   = EX_XLEN,
    parameter int REG_AW = EX_REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_wren,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_wren,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    always_comb begin
        fwd_data = rs_data;
        if (fwd_match(rs_addr, mem_rd_addr, mem_rd_wren)) begin
            fwd_data = mem_data;
        end else if (fwd_match(rs_addr, wb_rd_addr, wb_rd_wren)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, ALU operand select and load-use detection.
// Latency: ID instruction on EX outputs one cycle after capture; operands are combinational from it.
// Backpressure: i_stall holds EX, i_flush loads a bubble (wins); EX_PERF_CNT_EN adds counters.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int XLEN   = EX_XLEN,
    parameter int REG_AW = EX_REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [3:0]        i_id_alu_op,
    input  logic [1:0]        i_id_opa_sel,
    input  logic [1:0]        i_id_opb_sel,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_rd_wren,
    input  logic              i_id_mem_rden,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic              i_mem_rd_wren,
    input  logic              i_wb_rd_wren,
    input  logic [XLEN-1:0]   i_mem_fwd_data,
    input  logic [XLEN-1:0]   i_wb_fwd_data,
    output logic [XLEN-1:0]   o_operand_a,
    output logic [XLEN-1:0]   o_operand_b,
    output logic [3:0]        o_alu_op,
    output logic [XLEN-1:0]   o_store_data,
    output logic [XLEN-1:0]   o_pc,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic              o_rd_wren,
    output logic              o_mem_rden,
    output logic              o_valid,
    output logic              o_load_use
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]       o_fwd_cnt,
    output logic [31:0]       o_bubble_cnt
`endif
);

    id_ex_pkt_t      ex_q;
    id_ex_pkt_t      id_pkt;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        id_pkt          = bubble_pkt();
        id_pkt.valid    = i_id_valid;
        id_pkt.pc       = i_id_pc;
        id_pkt.rs1_addr = i_id_rs1_addr;
        id_pkt.rs2_addr = i_id_rs2_addr;
        id_pkt.rs1_data = i_id_rs1_data;
        id_pkt.rs2_data = i_id_rs2_data;
        id_pkt.imm      = i_id_imm;
        id_pkt.alu_op   = i_id_alu_op;
        id_pkt.opa_sel  = opa_sel_e'(i_id_opa_sel);
        id_pkt.opb_sel  = opb_sel_e'(i_id_opb_sel);
        id_pkt.rd_addr  = i_id_rd_addr;
        id_pkt.rd_wren  = i_id_rd_wren;
        id_pkt.mem_rden = i_id_mem_rden;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            ex_q <= bubble_pkt();
        end else if (!i_stall) begin
            ex_q <= id_pkt;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr     (ex_q.rs1_addr),
        .rs_data     (ex_q.rs1_data),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_rd_wren (i_mem_rd_wren),
        .mem_data    (i_mem_fwd_data),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_rd_wren  (i_wb_rd_wren),
        .wb_data     (i_wb_fwd_data),
        .fwd_data    (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr     (ex_q.rs2_addr),
        .rs_data     (ex_q.rs2_data),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_rd_wren (i_mem_rd_wren),
        .mem_data    (i_mem_fwd_data),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_rd_wren  (i_wb_rd_wren),
        .wb_data     (i_wb_fwd_data),
        .fwd_data    (fwd_rs2)
    );

    always_comb begin
        case (ex_q.opa_sel)
            OPA_RS1: o_operand_a = fwd_rs1;
            OPA_PC:  o_operand_a = ex_q.pc;
            default: o_operand_a = '0;
        endcase
        case (ex_q.opb_sel)
            OPB_RS2:  o_operand_b = fwd_rs2;
            OPB_IMM:  o_operand_b = ex_q.imm;
            OPB_FOUR: o_operand_b = XLEN'(4);
            default:  o_operand_b = '0;
        endcase
    end

    assign o_alu_op     = ex_q.alu_op;
    assign o_store_data = fwd_rs2;
    assign o_pc         = ex_q.pc;
    assign o_rd_addr    = ex_q.rd_addr;
    assign o_rd_wren    = ex_q.valid & ex_q.rd_wren;
    assign o_mem_rden   = ex_q.valid & ex_q.mem_rden;
    assign o_valid      = ex_q.valid;

    // Load data only exists after MEM, so a dependent instruction in ID must wait one cycle.
    assign o_load_use = ex_q.valid && ex_q.mem_rden && (ex_q.rd_addr != '0) && i_id_valid &&
                        ((ex_q.rd_addr == i_id_rs1_addr) || (ex_q.rd_addr == i_id_rs2_addr));

`ifdef EX_PERF_CNT_EN
    logic fwd_used;

    always_comb begin
        fwd_used = ((ex_q.opa_sel == OPA_RS1) &&
                    (fwd_match(ex_q.rs1_addr, i_mem_rd_addr, i_mem_rd_wren) ||
                     fwd_match(ex_q.rs1_addr, i_wb_rd_addr, i_wb_rd_wren))) ||
                   ((ex_q.opb_sel == OPB_RS2) &&
                    (fwd_match(ex_q.rs2_addr, i_mem_rd_addr, i_mem_rd_wren) ||
                     fwd_match(ex_q.rs2_addr, i_wb_rd_addr, i_wb_rd_wren)));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_fwd_cnt    <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (i_flush) begin
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
            end
            if (ex_q.valid && !i_stall && fwd_used) begin
                o_fwd_cnt <= o_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Builds the ID/EX pipeline register for the RV32I pipeline and produces the operands for the ALU.
- Latches the decoded instruction from ID and forwards results from the MEM and WB stages.
- Selects operand sources and drives `o_operand_a`, `o_operand_b` and `o_alu_op`. These feed the ALU directly, with no further registering.
- Detects load-use hazards, so that ID can stall and a bubble is inserted.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_stall  in  1  hold the EX register contents (from the hazard/memory controller)
- i_flush  in  1  load a bubble into EX (branch/jump redirect)
- i_id_valid  in  1  ID holds a real instruction
- i_id_pc  in  XLEN  instruction PC
- i_id_rs1_addr, i_id_rs2_addr  in  REG_AW each  source register addresses
- i_id_rs1_data, i_id_rs2_data  in  XLEN each  register file read data
- i_id_imm  in  XLEN  sign-extended immediate
- i_id_alu_op  in  4  ALU opcode: ADD=0 SUB=1 SLT=2 SLTU=3 XOR=4 OR=5 AND=6 SLL=7 SRL=8 SRA=9
- i_id_opa_sel  in  2  operand A source: 0=rs1, 1=pc, 2=zero
- i_id_opb_sel  in  2  operand B source: 0=rs2, 1=imm, 2=const 4
- i_id_rd_addr  in  REG_AW  destination register
- i_id_rd_wren  in  1  instruction writes rd
- i_id_mem_rden  in  1  instruction is a load
- i_mem_rd_addr, i_wb_rd_addr  in  REG_AW each  destination registers in MEM and WB
- i_mem_rd_wren, i_wb_rd_wren  in  1 each  MEM / WB write enables
- i_mem_fwd_data  in  XLEN  ALU result currently in MEM
- i_wb_fwd_data  in  XLEN  final write-back data in WB
- o_operand_a, o_operand_b  out  XLEN each  ALU operands
- o_alu_op  out  4  ALU opcode
- o_store_data  out  XLEN  forwarded rs2 value (store data)
- o_pc  out  XLEN  EX PC
- o_rd_addr  out  REG_AW  EX destination register
- o_rd_wren  out  1  EX write enable, already qualified by valid
- o_mem_rden  out  1  EX is a load, already qualified by valid
- o_valid  out  1  EX holds a real instruction
- o_load_use  out  1  ID must stall one cycle

Behaviour:
- Reset, while i_rst_n=0 at a clock edge, clears all EX registers:
  - valid, rd_wren and mem_rden = 0
  - pc, data, imm and addresses = 0
  - alu_op = ADD, opa_sel = 0, opb_sel = 0
  - Resulting outputs: o_operand_a = o_operand_b = 0, o_store_data = 0, o_pc = 0, o_rd_addr = 0, o_rd_wren = 0, o_mem_rden = 0, o_valid = 0, o_alu_op = ADD, o_load_use = 0.
- Reset mid-operation discards the in-flight instruction.
- Register update, in priority order at each clock edge:
  1. Reset.
  2. i_flush=1: load a bubble. valid, rd_wren and mem_rden = 0; other fields don't-care, but held at their reset values. Flush wins over stall.
  3. i_stall=1: hold all fields.
  4. Otherwise: capture all ID inputs.
- Latency: an ID instruction appears on the EX outputs one cycle after capture.
- Forwarding is combinational from the registered rs addresses. For each source rsN:
  - If MEM has rd_wren=1, rd≠0 and rd==rsN, use i_mem_fwd_data.
  - Else if WB has rd_wren=1, rd≠0 and rd==rsN, use i_wb_fwd_data.
  - Else use the registered rsN data.
  - MEM has priority over WB.
  - rsN==x0 never forwards and always yields the registered data (which the register file drives as 0).
- Operand muxes:
  - Operand A: opa_sel picks fwd_rs1, pc or 0.
  - Operand B: opb_sel picks fwd_rs2, imm or 32'd4.
  - Encoding 3 on either select decodes as 0 (default).
- o_store_data is always fwd_rs2, regardless of opb_sel.
- Load-use hazard:
  - o_load_use = o_valid & mem_rden & rd≠0 & i_id_valid & (rd==i_id_rs1_addr | rd==i_id_rs2_addr).
  - It is combinational; the external controller turns it into stall-ID plus flush-EX.
- Outputs are defined even when o_valid=0; consumers must qualify them with o_valid.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- Defined:
  - Adds outputs o_fwd_cnt (32) and o_bubble_cnt (32), both reset to 0.
  - o_fwd_cnt increments once per cycle while o_valid=1, the stage is not stalled, and any operand uses forwarded data.
  - o_bubble_cnt increments each cycle in which a bubble is loaded by flush.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ex_pkg contains:
  - ALU opcode localparams (4-bit, values as listed under Ports)
  - opa_sel_e and opb_sel_e enums
  - typedef struct id_ex_pkt_t holding all registered fields
- One sub-module, fwd_mux:
  - Inputs: rs address, registered data, MEM/WB rd addresses, write enables and data.
  - Output: the forwarded value.
  - Instantiated twice, for rs1 and rs2.

Test Plan:
1. Reset then ADD x3,x1,x2 with rs1_data=5, rs2_data=7, no hazards -> next cycle o_operand_a=5, o_operand_b=7, o_alu_op=0, o_valid=1.
2. EX rs1=x4, MEM rd=x4 wren data=0xAA, WB rd=x4 wren data=0xBB -> o_operand_a=0xAA; repeat with MEM wren=0 -> 0xBB; repeat with rs1=x0 and rd=x0 -> registered data (0).
3. ADDI with opb_sel=imm, imm=0xFFFFFFFF; JAL with opa_sel=pc, pc=0x100, opb_sel=4 -> o_operand_b=0xFFFFFFFF; then o_operand_a=0x100, o_operand_b=4.
4. EX is a load with rd=x5; ID valid with rs2=x5 -> o_load_use=1; ID rs1=rs2=x6 -> 0; EX rd=x0 -> 0.
5. i_stall=1 for 3 cycles with changing ID inputs -> EX outputs constant; i_stall=1 and i_flush=1 together -> o_valid=0, o_rd_wren=0 next cycle.
6. Assert i_rst_n=0 with valid instruction in EX -> after the edge, all outputs at reset values; with EX_PERF_CNT_EN, 2 flushes and 1 forwarded op -> o_bubble_cnt=2, o_fwd_cnt=1.
